voice_mix_seq: RTL and testbench
================================

Name: voice_mix_seq

Overview:
- Audio-rate sequencer that feeds the shared shift-add multiplier.
- On each sample request it:
  - multiplies every enabled voice's signed 12-bit waveform by its 8-bit envelope;
  - accumulates the products;
  - multiplies the sum by the 4-bit master volume;
  - emits one 16-bit signed mixed sample.
- Sits between the voice/envelope generators and the output DAC/filter path, and owns the multiplier's start/op/ready/product interface.

Parameters:
- NUM_VOICES, 3, number of voices sequenced (1..4).
- OUT_SHIFT, 10, arithmetic right shift applied to the volume product before output.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, synchronous, active-low.
- sample_req_i  in  1  one-cycle pulse requesting a new mixed sample.
- voice_wave_i  in  NUM_VOICES*12  signed waveform per voice; voice v at [12v+11:12v].
- voice_env_i  in  NUM_VOICES*8  unsigned envelope per voice; voice v at [8v+7:8v].
- voice_en_i  in  NUM_VOICES  per-voice enable; 0 = voice skipped.
- volume_i  in  4  unsigned master volume.
- mult_start_o  out  1  multiplier start, one-cycle pulse.
- mult_op_a_o  out  24  signed multiplier operand A.
- mult_op_b_o  out  16  signed multiplier operand B.
- mult_ready_i  in  1  multiplier ready.
- mult_prod_i  in  40  signed multiplier product.
- mix_o  out  16  signed mixed sample, held until next update.
- mix_valid_o  out  1  one-cycle pulse when mix_o updates.
- busy_o  out  1  high while a sample is being computed.
- overrun_o  out  1  sticky flag: sample_req_i arrived while busy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values:
  - mix_o=0, mix_valid_o=0, busy_o=0, overrun_o=0, mult_start_o=0, mult_op_a_o=0, mult_op_b_o=0.
  - Accumulator=0, state=IDLE.
- State machine: IDLE -> ISSUE -> WAIT -> (next voice ISSUE | VOL_ISSUE) -> VOL_WAIT -> IDLE.
- IDLE:
  - On sample_req_i, latch voice_wave_i, voice_env_i, voice_en_i and volume_i into shadow registers, and clear the accumulator.
  - Select the lowest enabled voice and go to ISSUE. If no voice is enabled, go to VOL_ISSUE.
  - busy_o is high in every state except IDLE.
- ISSUE (one cycle):
  - mult_start_o=1.
  - op_a = sign-extended wave[v]; op_b = {8'd0, env[v]}.
  - Go to WAIT.
- WAIT:
  - Do not sample mult_ready_i in the ISSUE cycle. The multiplier deasserts ready during start and after reset.
  - On the first cycle with mult_ready_i=1: acc += mult_prod_i[21:0] (22-bit signed).
  - Then go to the next enabled voice's ISSUE, or to VOL_ISSUE after the last enabled voice.
  - Disabled voices consume no cycles.
- VOL_ISSUE:
  - mult_start_o=1.
  - op_a = sign-extended acc; op_b = {12'd0, volume}.
- VOL_WAIT:
  - On mult_ready_i, register mix_o = mult_prod_i[OUT_SHIFT+15:OUT_SHIFT]. This is an arithmetic shift that floors toward minus infinity; no rounding.
  - Pulse mix_valid_o in the following cycle; state returns to IDLE in that same cycle.
- Operands: mult_op_a_o and mult_op_b_o are registered and held stable from ISSUE until the next ISSUE.
- Range: with default widths no saturation is needed. Worst case is ±2048*255*3*15 = ±23,500,800, which is ±22,950 after the shift.
- Timing:
  - Each multiply takes 18 cycles: ISSUE, plus ready 17 cycles after start.
  - With sample_req_i in cycle 0, mix_valid_o is high in cycle 1 + 18*(N_enabled+1).
  - All voices enabled: cycle 73. No voices enabled: cycle 19.
- sample_req_i while busy_o=1:
  - The request is ignored, shadow registers are unchanged, and overrun_o is set.
  - overrun_o clears only on reset.
- sample_req_i in the mix_valid_o cycle: accepted (state is IDLE).
- Input changes after capture do not affect the sample in progress.
- Reset mid-operation: all outputs return to reset values on the next edge and mult_start_o stays low. The multiplier shares rst_ni.

Test Plan:
- Single voice: en=001, wave0=2047, env0=255, vol=15, req at cycle 0 -> mix_o=7646, mix_valid_o at cycle 37, exactly 2 mult_start_o pulses.
- All voices: wave=-2048 (0x800), env=255 for all, vol=15 -> mix_o=-22950, mix_valid_o at cycle 73, 4 start pulses.
- Mixed signs: en=011, wave0=1000/env0=200, wave1=-500/env1=100, vol=8 -> mix_o=1171, valid at cycle 55.
- Floor and all-disabled cases:
  - en=001, wave0=-1, env0=1, vol=1 -> mix_o=-1.
  - en=000, vol=15 -> mix_o=0, valid at cycle 19, exactly 1 start pulse.
- Overrun: second sample_req_i at cycle 10 with different inputs -> ignored, overrun_o=1 from cycle 11, result equals the first request's values. A req in the valid cycle is accepted.
- Reset: rst_ni low at cycle 30 of an all-voice op -> next cycle mix_o=0, busy_o=0, overrun_o=0, start low. A new request after release gives the correct value at the full latency.

Source files
------------

// File: rtl/voice_mix_seq.sv
`default_nettype none
// ==== voice_mix_seq : sequences voice x envelope and volume multiplies on a shared multiplier | rev 1.0 ====
module voice_mix_seq #(
  parameter int NUM_VOICES = 3,
  parameter int OUT_SHIFT  = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     sample_req_i,
  input  logic [NUM_VOICES*12-1:0] voice_wave_i,
  input  logic [NUM_VOICES*8-1:0]  voice_env_i,
  input  logic [NUM_VOICES-1:0]    voice_en_i,
  input  logic [3:0]               volume_i,
  output logic                     mult_start_o,
  output logic [23:0]              mult_op_a_o,
  output logic [15:0]              mult_op_b_o,
  input  logic                     mult_ready_i,
  input  logic [39:0]              mult_prod_i,
  output logic [15:0]              mix_o,
  output logic                     mix_valid_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int IW = 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT      = 3'd2;
  localparam logic [2:0] S_VOL_ISSUE = 3'd3;
  localparam logic [2:0] S_VOL_WAIT  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [NUM_VOICES*12-1:0] sh_wave_q, sh_wave_d;
  logic [NUM_VOICES*8-1:0]  sh_env_q, sh_env_d;
  logic [NUM_VOICES-1:0]    sh_en_q, sh_en_d;
  logic [3:0]               sh_vol_q, sh_vol_d;
  logic [IW-1:0]            vidx_q, vidx_d;
  logic [21:0]              acc_q, acc_d;
  logic                     start_q, start_d;
  logic [23:0]              op_a_q, op_a_d;
  logic [15:0]              op_b_q, op_b_d;
  logic [15:0]              mix_q, mix_d;
  logic                     valid_q, valid_d;
  logic                     ovr_q, ovr_d;

  logic                     first_found;
  logic [IW-1:0]            first_idx;
  logic                     nxt_found;
  logic [IW-1:0]            nxt_idx;
  logic [21:0]              acc_sum;
  logic                     unused_prod;

  assign acc_sum     = acc_q + mult_prod_i[21:0];
  assign unused_prod = ^mult_prod_i[39:OUT_SHIFT+16];

  // Descending scan so the lowest qualifying voice index wins.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_en_i[v]) begin
        first_found = 1'b1;
        first_idx   = IW'(v);
      end
      if (sh_en_q[v] && (v > int'(vidx_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = IW'(v);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_wave_d = sh_wave_q;
    sh_env_d  = sh_env_q;
    sh_en_d   = sh_en_q;
    sh_vol_d  = sh_vol_q;
    vidx_d    = vidx_q;
    acc_d     = acc_q;
    start_d   = 1'b0;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    mix_d     = mix_q;
    valid_d   = 1'b0;
    ovr_d     = ovr_q | (sample_req_i & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (sample_req_i) begin
          sh_wave_d = voice_wave_i;
          sh_env_d  = voice_env_i;
          sh_en_d   = voice_en_i;
          sh_vol_d  = volume_i;
          acc_d     = '0;
          start_d   = 1'b1;
          if (first_found) begin
            vidx_d  = first_idx;
            state_d = S_ISSUE;
            op_a_d  = {{12{voice_wave_i[12*int'(first_idx)+11]}},
                       voice_wave_i[12*int'(first_idx) +: 12]};
            op_b_d  = {8'd0, voice_env_i[8*int'(first_idx) +: 8]};
          end else begin
            state_d = S_VOL_ISSUE;
            op_a_d  = '0;
            op_b_d  = {12'd0, volume_i};
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mult_ready_i) begin
          acc_d   = acc_sum;
          start_d = 1'b1;
          if (nxt_found) begin
            vidx_d  = nxt_idx;
            state_d = S_ISSUE;
            op_a_d  = {{12{sh_wave_q[12*int'(nxt_idx)+11]}},
                       sh_wave_q[12*int'(nxt_idx) +: 12]};
            op_b_d  = {8'd0, sh_env_q[8*int'(nxt_idx) +: 8]};
          end else begin
            state_d = S_VOL_ISSUE;
            op_a_d  = {{2{acc_sum[21]}}, acc_sum};
            op_b_d  = {12'd0, sh_vol_q};
          end
        end
      end
      S_VOL_ISSUE: state_d = S_VOL_WAIT;
      S_VOL_WAIT: begin
        if (mult_ready_i) begin
          mix_d   = mult_prod_i[OUT_SHIFT+15:OUT_SHIFT];
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      sh_wave_q <= '0;
      sh_env_q  <= '0;
      sh_en_q   <= '0;
      sh_vol_q  <= '0;
      vidx_q    <= '0;
      acc_q     <= '0;
      start_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      mix_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_wave_q <= sh_wave_d;
      sh_env_q  <= sh_env_d;
      sh_en_q   <= sh_en_d;
      sh_vol_q  <= sh_vol_d;
      vidx_q    <= vidx_d;
      acc_q     <= acc_d;
      start_q   <= start_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      mix_q     <= mix_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign mult_start_o = start_q;
  assign mult_op_a_o  = op_a_q;
  assign mult_op_b_o  = op_b_q;
  assign mix_o        = mix_q;
  assign mix_valid_o  = valid_q;
  assign busy_o       = (state_q != S_IDLE);
  assign overrun_o    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_mix_seq.sv
`default_nettype none
// ==== tb_voice_mix_seq : table + scoreboard bench with a behavioural 18-cycle multiplier | rev 1.0 ====
module tb_voice_mix_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_req;
  logic [35:0] wave;
  logic [23:0] env;
  logic [2:0]  en;
  logic [3:0]  vol;
  logic        mult_start;
  logic [23:0] op_a;
  logic [15:0] op_b;
  logic        m_ready;
  logic [39:0] m_prod;
  logic [15:0] mix;
  logic        mix_valid;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  voice_mix_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .sample_req_i (sample_req),
    .voice_wave_i (wave),
    .voice_env_i  (env),
    .voice_en_i   (en),
    .volume_i     (vol),
    .mult_start_o (mult_start),
    .mult_op_a_o  (op_a),
    .mult_op_b_o  (op_b),
    .mult_ready_i (m_ready),
    .mult_prod_i  (m_prod),
    .mix_o        (mix),
    .mix_valid_o  (mix_valid),
    .busy_o       (busy),
    .overrun_o    (overrun)
  );

  // Multiplier: product captured at start, ready 17 cycles after start, held until next start.
  logic m_active;
  int   m_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_cnt    <= 0;
      m_prod   <= '0;
    end else if (mult_start) begin
      m_active <= 1'b1;
      m_cnt    <= 1;
      m_prod   <= $signed(op_a) * $signed(op_b);
    end else if (m_active && m_cnt < 17) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign m_ready = m_active && (m_cnt == 17);

  typedef struct {
    logic [2:0]  en;
    logic [35:0] wave;
    logic [23:0] env;
    logic [3:0]  vol;
    int          exp_mix;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int mix;
    int lat;
    int starts;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic [2:0] e, logic [35:0] w, logic [23:0] n,
                              logic [3:0] v, int m, int l);
    vec_t r;
    r.en = e; r.wave = w; r.env = n; r.vol = v; r.exp_mix = m; r.exp_lat = l;
    return r;
  endfunction

  function automatic int model_mix(vec_t v);
    longint s = 0;
    for (int i = 0; i < 3; i++)
      if (v.en[i])
        s += longint'($signed(v.wave[12*i +: 12])) * longint'(v.env[8*i +: 8]);
    s = s * longint'(v.vol);
    return int'(s >>> 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    wave = v.wave; env = v.env; en = v.en; vol = v.vol;
  endtask

  task automatic scramble();
    wave = 36'({$urandom(), $urandom()});
    env  = 24'($urandom());
    en   = 3'($urandom());
    vol  = 4'($urandom());
  endtask

  // Drives one request now (cycle 0); optionally injects a second request at inj_cyc.
  task automatic do_sample(input vec_t v, input int inj_cyc, input vec_t inj);
    exp_t e;
    int   k;
    int   starts;
    bit   done;
    apply(v);
    sample_req = 1'b1;
    e.mix = v.exp_mix; e.lat = v.exp_lat; e.starts = $countones(v.en) + 1;
    sb.push_back(e);
    starts = 0;
    done   = 1'b0;
    @(negedge clk);
    k = 1;
    sample_req = 1'b0;
    scramble();
    while (!done && k <= 300) begin
      if (mult_start) starts++;
      if (k == 5) chk("busy_mid", int'(busy), 1);
      if (inj_cyc > 0 && k == inj_cyc + 1) chk("overrun_set", int'(overrun), 1);
      if (mix_valid) done = 1'b1;
      else begin
        if (k == inj_cyc) begin apply(inj); sample_req = 1'b1; end
        else sample_req = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    e = sb.pop_front();
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no mix_valid after %0d cycles, expected at %0d", k, e.lat);
    end else begin
      chk("mix", int'($signed(mix)), e.mix);
      chk("latency", k, e.lat);
      chk("start_pulses", starts, e.starts);
      chk("busy_valid_cycle", int'(busy), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    rst_n = 1'b0; sample_req = 1'b0;
    wave = '0; env = '0; en = '0; vol = '0;

    tbl[0] = mk(3'b001, {12'd0, 12'd0, 12'h7FF}, {8'd0, 8'd0, 8'd255}, 4'd15, 7646, 37);
    tbl[1] = mk(3'b111, {3{12'h800}}, {3{8'hFF}}, 4'd15, -22950, 73);
    tbl[2] = mk(3'b011, {12'h123, 12'hE0C, 12'h3E8}, {8'd50, 8'd100, 8'd200}, 4'd8, 1171, 55);
    tbl[3] = mk(3'b001, {12'h555, 12'h555, 12'hFFF}, {8'd9, 8'd9, 8'd1}, 4'd1, -1, 37);
    tbl[4] = mk(3'b000, {12'h7FF, 12'h7FF, 12'h7FF}, {3{8'hFF}}, 4'd15, 0, 19);
    tbl[5] = mk(3'b100, {12'h400, 12'h7FF, 12'h7FF}, {8'd128, 8'd255, 8'd255}, 4'd3, 384, 37);
    tbl[6] = mk(3'b101, {12'h005, 12'h7FF, 12'hFF9}, {8'd2, 8'd255, 8'd3}, 4'd1, -1, 55);

    repeat (3) @(negedge clk);
    chk("rst_mix", int'(mix), 0);
    chk("rst_valid", int'(mix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_start", int'(mult_start), 0);
    chk("rst_op_a", int'(op_a), 0);
    chk("rst_op_b", int'(op_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_sample(tbl[i], 0, tbl[0]);
      if (i == 0) continue;  // next request lands in the valid cycle
      chk("mix_held", int'($signed(mix)), tbl[i].exp_mix);
      @(negedge clk);
      chk("mix_held_next", int'($signed(mix)), tbl[i].exp_mix);
    end

    for (int i = 0; i < 4; i++) begin
      r.en   = 3'($urandom());
      r.wave = 36'({$urandom(), $urandom()});
      r.env  = 24'($urandom());
      r.vol  = 4'($urandom());
      r.exp_mix = model_mix(r);
      r.exp_lat = 1 + 18 * ($countones(r.en) + 1);
      do_sample(r, 0, tbl[0]);
      @(negedge clk);
    end

    chk("overrun_clear", int'(overrun), 0);
    do_sample(tbl[2], 10, tbl[1]);
    do_sample(tbl[3], 0, tbl[0]);

    apply(tbl[1]);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    for (int k = 1; k < 30; k++) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mix", int'(mix), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_start", int'(mult_start), 0);
    chk("midrst_valid", int'(mix_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_start", int'(mult_start), 0);
    do_sample(tbl[2], 0, tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
